// File: rtl/addr8s_pkg.sv
// Shared types and widths for the dual-order (a+b / b+a) adder scheduler.
package addr8s_pkg;

  localparam int OPW  = 8;  // operand width
  localparam int SUMW = 9;  // adder result width
  localparam int RETW = 3;  // retry counter width
  localparam int FCW  = 8;  // fault counter width

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN1 = 3'd1,
    RUN2 = 3'd2,
    CMP  = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage

// File: rtl/addr8s_tmr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr wins,
// otherwise wraps to the lowest requester overall.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [NREQ-1:0] upper;
  logic [NREQ-1:0] sel;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign upper[gi] = req[gi] && (IDW'(gi) >= ptr);
  end

  assign any = |req;

  always_comb begin
    sel = (|upper) ? upper : req;
    idx = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (sel[i]) idx = IDW'(i);
    end
  end

  always_comb begin
    grant = '0;
    if (any) grant = NREQ'(1) << idx;
  end

endmodule

// File: rtl/addr8s_tmr_sched.sv
// Shares one external 8-bit signed adder between requesters; each addition is
// run in both operand orders and retried on disagreement to expose transients.
module addr8s_tmr_sched
  import addr8s_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int MAX_RETRY = 2,
  parameter int IDW       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_a,
  input  logic [NREQ*OPW-1:0]  req_b,
  output logic [OPW-1:0]       adr_a,
  output logic [OPW-1:0]       adr_b,
  input  logic [SUMW-1:0]      adr_sum,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [SUMW-1:0]      rsp_sum,
  output logic                 rsp_err,
  output logic [RETW-1:0]      rsp_retries,
  output logic [FCW-1:0]       fault_cnt,
  output logic                 busy
);

  state_t            state_reg;
  logic [IDW-1:0]    ptr_reg;
  logic [IDW-1:0]    id_reg;
  logic [OPW-1:0]    a_reg;
  logic [OPW-1:0]    b_reg;
  logic [RETW-1:0]   retry_reg;
  logic [SUMW-1:0]   r1_reg;
  logic [SUMW-1:0]   r2_reg;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              grant_any;
  logic [IDW-1:0]    ptr_next;
  logic [OPW-1:0]    a_arr [NREQ];
  logic [OPW-1:0]    b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
    assign a_arr[gi] = req_a[gi*OPW +: OPW];
    assign b_arr[gi] = req_b[gi*OPW +: OPW];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign ptr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  assign req_ready = (state_reg == IDLE && !rst) ? grant : '0;
  assign busy      = (state_reg != IDLE);

  // CMP keeps the swapped order so the adder inputs only change on retry.
  always_comb begin
    adr_a = '0;
    adr_b = '0;
    case (state_reg)
      RUN1: begin
        adr_a = a_reg;
        adr_b = b_reg;
      end
      RUN2, CMP: begin
        adr_a = b_reg;
        adr_b = a_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      id_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      retry_reg   <= '0;
      r1_reg      <= '0;
      r2_reg      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_sum     <= '0;
      rsp_err     <= 1'b0;
      rsp_retries <= '0;
      fault_cnt   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            a_reg     <= a_arr[grant_idx];
            b_reg     <= b_arr[grant_idx];
            id_reg    <= grant_idx;
            retry_reg <= '0;
            ptr_reg   <= ptr_next;
            state_reg <= RUN1;
          end
        end
        RUN1: begin
          r1_reg    <= adr_sum;
          state_reg <= RUN2;
        end
        RUN2: begin
          r2_reg    <= adr_sum;
          state_reg <= CMP;
        end
        CMP: begin
          if (r1_reg == r2_reg) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= id_reg;
            rsp_sum     <= r1_reg;
            rsp_err     <= 1'b0;
            rsp_retries <= retry_reg;
            state_reg   <= RESP;
          end else begin
            if (fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
            if (retry_reg < RETW'(MAX_RETRY)) begin
              retry_reg <= retry_reg + 1'b1;
              state_reg <= RUN1;
            end else begin
              // Out of retries: report the in-order result, flagged.
              rsp_valid   <= 1'b1;
              rsp_id      <= id_reg;
              rsp_sum     <= r1_reg;
              rsp_err     <= 1'b1;
              rsp_retries <= retry_reg;
              state_reg   <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr8s_tmr_sched.sv
// Directed and randomized checks of addr8s_tmr_sched against a transaction-level
// model: round-robin order, sums, retry/error outcome, latency, fault count.
module tb_addr8s_tmr_sched;

  localparam int NREQ      = 3;
  localparam int MAX_RETRY = 2;
  localparam int IDW       = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a = '0;
  logic [NREQ*8-1:0] req_b = '0;
  logic [7:0]        adr_a;
  logic [7:0]        adr_b;
  logic [8:0]        adr_sum;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [8:0]        rsp_sum;
  logic              rsp_err;
  logic [2:0]        rsp_retries;
  logic [7:0]        fault_cnt;
  logic              busy;
  logic [8:0]        corrupt = '0;

  addr8s_tmr_sched #(
    .NREQ      (NREQ),
    .MAX_RETRY (MAX_RETRY),
    .IDW       (IDW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .adr_a       (adr_a),
    .adr_b       (adr_b),
    .adr_sum     (adr_sum),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_sum     (rsp_sum),
    .rsp_err     (rsp_err),
    .rsp_retries (rsp_retries),
    .fault_cnt   (fault_cnt),
    .busy        (busy)
  );

  // External adder: ideal signed add, with an optional injected bit flip.
  assign adr_sum = ({adr_a[7], adr_a} + {adr_b[7], adr_b}) ^ corrupt;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;
  int fault_m = 0;
  logic signed [7:0] opa [NREQ];
  logic signed [7:0] opb [NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic load_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = opa[i];
      req_b[8*i +: 8] = opb[i];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_adr_a"}, adr_a, 0);
    chk({tag, "_adr_b"}, adr_b, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_sum"}, rsp_sum, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_retries"}, rsp_retries, 0);
    chk({tag, "_fault_cnt"}, fault_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // mode 0: clean adder, 1: first swapped pass corrupted, 2: every swapped pass corrupted.
  task automatic run_op(input logic [NREQ-1:0] vmask, input int mode, input int hold, input bit keep);
    int g, cyc, lat, nf, exp_ret, s;
    bit exp_err;
    logic [NREQ-1:0] expg;
    logic [8:0] exp_sum;
    load_ops();
    req_valid = vmask;
    corrupt   = '0;
    rsp_ready = (hold == 0);
    #1;
    g = model_grant(vmask);
    expg = '0;
    expg[g] = 1'b1;
    chk("grant", req_ready, expg);
    chk("idle_busy", busy, 0);
    chk("idle_adr_a", adr_a, 0);
    chk("idle_adr_b", adr_b, 0);
    ptr_m = (g + 1) % NREQ;
    s = int'(opa[g]) + int'(opb[g]);
    exp_sum = 9'(s);
    case (mode)
      1:       begin nf = 1;             exp_ret = 1;         exp_err = 1'b0; end
      2:       begin nf = MAX_RETRY + 1; exp_ret = MAX_RETRY; exp_err = 1'b1; end
      default: begin nf = 0;             exp_ret = 0;         exp_err = 1'b0; end
    endcase
    lat = 4 + 3 * exp_ret;
    fault_m = (fault_m + nf > 255) ? 255 : fault_m + nf;

    @(negedge clk);
    if (!keep) req_valid = '0;
    cyc = 1;
    while (1) begin
      corrupt = ((mode == 1 && cyc == 2) || (mode == 2 && cyc % 3 == 2)) ? 9'h004 : 9'h000;
      if (rsp_valid === 1'b1 || cyc >= 40) break;
      if (cyc == 1) begin
        chk("run1_a", adr_a, $unsigned(opa[g]));
        chk("run1_b", adr_b, $unsigned(opb[g]));
        chk("run_busy", busy, 1);
      end
      if (cyc == 2) begin
        chk("run2_a", adr_a, $unsigned(opb[g]));
        chk("run2_b", adr_b, $unsigned(opa[g]));
      end
      if (keep) chk("busy_no_ready", req_ready, 0);
      @(negedge clk);
      cyc++;
    end
    corrupt = '0;
    chk("latency", cyc, lat);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, g);
    chk("rsp_sum", rsp_sum, exp_sum);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_retries", rsp_retries, exp_ret);
    chk("fault_cnt", fault_cnt, fault_m);
    if (keep) chk("resp_no_ready", req_ready, 0);
    $display("op id=%0d a=%0d b=%0d sum=%0d err=%0b retries=%0d lat=%0d faults=%0d",
             g, opa[g], opb[g], $signed(rsp_sum), rsp_err, rsp_retries, cyc, fault_cnt);

    if (hold > 0) begin
      req_valid = '1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("hold_valid", rsp_valid, 1);
        chk("hold_id", rsp_id, g);
        chk("hold_sum", rsp_sum, exp_sum);
        chk("hold_err", rsp_err, exp_err);
        chk("hold_retries", rsp_retries, exp_ret);
        chk("hold_no_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);
    chk("back_idle", busy, 0);
    rsp_ready = 1'b0;
    req_valid = '0;
  endtask

  task automatic reset_mid(input logic [NREQ-1:0] vmask);
    int g;
    logic [NREQ-1:0] expg;
    load_ops();
    req_valid = vmask;
    rsp_ready = 1'b0;
    #1;
    g = model_grant(vmask);
    expg = '0;
    expg[g] = 1'b1;
    chk("rm_grant", req_ready, expg);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("rm_run2_busy", busy, 1);
    chk("rm_run2_a", adr_a, $unsigned(opb[g]));
    rst = 1'b1;
    @(negedge clk);
    ptr_m   = 0;
    fault_m = 0;
    chk_all_zero("rm");
    rst = 1'b0;
    $display("reset during operation of id=%0d", g);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rm_no_rsp", rsp_valid, 0);
      chk("rm_idle", busy, 0);
    end
  endtask

  initial begin
    // Reset with every requester asserting valid.
    req_valid = '1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    // Basic operation and sum extremes.
    opa[0] = 8'sd100;  opb[0] = 8'sd27;
    run_op(3'b001, 0, 0, 1'b0);
    opa[1] = 8'sd127;  opb[1] = 8'sd127;
    run_op(3'b010, 0, 0, 1'b0);
    opa[2] = -8'sd128; opb[2] = -8'sd128;
    run_op(3'b100, 0, 0, 1'b0);

    // All requesters held valid, response always accepted.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        opa[i] = 8'($urandom);
        opb[i] = 8'($urandom);
      end
      run_op(3'b111, 0, 0, 1'b1);
    end

    opa[0] = -8'sd128; opb[0] = 8'sd127;
    run_op(3'b001, 0, 0, 1'b0);

    // Single transient, then a persistent order-dependent fault.
    opa[1] = 8'sd55;   opb[1] = -8'sd17;
    run_op(3'b010, 1, 0, 1'b0);
    opa[2] = -8'sd3;   opb[2] = 8'sd90;
    run_op(3'b100, 2, 0, 1'b0);

    // Response back-pressure while others request.
    opa[2] = 8'sd64;   opb[2] = 8'sd33;
    run_op(3'b100, 0, 5, 1'b0);

    // Reset during the swapped pass of the next operation.
    opa[1] = 8'sd12;   opb[1] = 8'sd34;
    reset_mid(3'b010);
    opa[0] = 8'sd1;    opb[0] = -8'sd1;
    run_op(3'b111, 0, 0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        opa[i] = 8'($urandom);
        opb[i] = 8'($urandom);
      end
      run_op(NREQ'($urandom_range(1, (1 << NREQ) - 1)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Drive the fault counter into saturation.
    for (int n = 0; n < 86; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        opa[i] = 8'($urandom);
        opb[i] = 8'($urandom);
      end
      run_op(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 2, 0, 1'b0);
    end
    chk("fault_sat", fault_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr8s_tmr_sched.md
Name: addr8s_tmr_sched

Overview:
- Controller that shares one external combinational 8-bit signed adder (A[7:0] + B[7:0] -> O[8:0]) between NREQ requesters.
- Arbitrates round-robin and runs each granted addition twice: (a,b), then swapped (b,a). It compares the two results to detect transient faults.
- Retries on mismatch up to MAX_RETRY times, then returns the result with an error flag.
- Sits between client logic and an evolved fault-resilient adder netlist.

Parameters:
- NREQ, 3, number of requesters (2..8).
- MAX_RETRY, 2, maximum re-executions after a mismatch (1..7).
- IDW, 2, requester-id width; must be at least ceil(log2(NREQ)).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operation valid.
- req_ready  output  NREQ  per-requester accept (one-hot or zero).
- req_a  input  NREQ*8  packed signed operand A, requester i at [8i+7:8i].
- req_b  input  NREQ*8  packed signed operand B.
- adr_a  output  8  to shared adder A input.
- adr_b  output  8  to shared adder B input.
- adr_sum  input  9  from shared adder O[8:0], signed.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  IDW  requester index of the response.
- rsp_sum  output  9  signed sum.
- rsp_err  output  1  unrecoverable mismatch.
- rsp_retries  output  3  retries used.
- fault_cnt  output  8  saturating count of mismatches since reset.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, RR pointer 0, fault_cnt 0. Reset mid-operation aborts it; the pending response is discarded.
- State IDLE:
  - Grant goes to the lowest index >= pointer with req_valid, wrapping. req_ready[grant] is combinational, this cycle only.
  - On handshake: latch a, b and id; retry count = 0; pointer = (grant+1) mod NREQ; go to RUN1.
  - adr_a and adr_b are 0 in IDLE.
- RUN1: drive adr_a=a, adr_b=b; register adr_sum into r1; go to RUN2.
- RUN2: drive adr_a=b, adr_b=a; register adr_sum into r2; go to CMP.
- CMP: adder inputs hold (b,a).
  - r1==r2: go to RESP, err=0.
  - Mismatch: fault_cnt increments, saturating at 255.
    - retry < MAX_RETRY: retry++, go to RUN1.
    - Otherwise: go to RESP with err=1, rsp_sum=r1.
- RESP:
  - rsp_valid=1; rsp_id, rsp_sum, rsp_err, rsp_retries held stable while rsp_ready=0.
  - No new grants in RESP.
  - On rsp_valid&&rsp_ready: go to IDLE. The next grant can occur one cycle later, in IDLE.
- Latency, fault-free: handshake in cycle 0 -> rsp_valid in cycle 4. Each retry adds 3 cycles.
- Arithmetic: no overflow possible; sum range -256..+254 in 9-bit two's complement. The controller never modifies adr_sum.
- req_valid dropping while not granted: legal, no effect. Operands are sampled only at the handshake.
- Back-to-back operation from the same requester: allowed. The pointer still advances past it.

Decomposition:
- Shared package addr8s_pkg:
  - state enum (IDLE, RUN1, RUN2, CMP, RESP);
  - operand width 8 and sum width 9 constants;
  - retry-counter width 3.
- Sub-module rr_arbiter (NREQ):
  - inputs: req vector, pointer;
  - outputs: one-hot grant, encoded index, any.
  - Purely combinational, instantiated once.

Test Plan:
- Req0 a=100, b=27 with an ideal adder model -> req_ready[0] in cycle 0; rsp_valid cycle 4, rsp_sum=9'h07F, id=0, err=0, retries=0.
- Extremes: 127+127 -> 9'h0FE; -128+-128 -> 9'h100; -128+127 -> 9'h1FF; all err=0.
- All three requesters held valid continuously with rsp_ready=1 -> grant order 0,1,2,0,1,2; each response id matches and sums are correct.
- Adder model corrupts the sum only in the first RUN2 -> retries=1, err=0, correct sum, fault_cnt=1, rsp_valid in cycle 7.
- Adder model always differs between orders (stuck bit on swapped inputs), MAX_RETRY=2 -> err=1, retries=2, fault_cnt=3, rsp_valid in cycle 10.
- rsp_ready low 5 cycles in RESP with req1 valid -> response fields stable, req_ready stays 0. Then assert rst during RUN2 of the next operation -> next cycle all outputs 0, busy=0, no response emitted.
